// File: rtl/bpsk_bit_framer.sv
// Byte FIFO plus preamble/payload framer driving the 1-bit BPSK phase select line.
// Latency: first preamble bit at the first carrier boundary at least one edge after a push into an empty idle FIFO.
// Backpressure: in_ready = !full from registered occupancy; in_valid while !in_ready is ignored.

module bpsk_byte_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  output logic             wr_rdy,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign wr_rdy  = (count != CW'(DEPTH));
  assign rd_vld  = (count != '0);
  assign do_push = wr_vld && wr_rdy;
  assign do_pop  = rd_rdy && rd_vld;
  assign rd_dat  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end
endmodule

module bpsk_bit_framer #(
  parameter int          SAMPLES_PER_BIT = 20,
  parameter int          PREAMBLE_LEN    = 16,
  parameter logic [31:0] PREAMBLE        = 32'hAAAA,
  parameter int          FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_byte,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       data,
  output logic       sym_strobe,
  output logic       tx_active,
  output logic       frame_done,
  output logic       underrun
);
  localparam int               CNT_W        = $clog2(SAMPLES_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(SAMPLES_PER_BIT - 1);
  // Preamble left-justified so the first bit to send always sits in bit 31.
  localparam logic [31:0]      PRE_ALIGNED  = PREAMBLE << (32 - PREAMBLE_LEN);
  localparam logic [4:0]       PRE_LAST_IDX = 5'(PREAMBLE_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             boundary;
  logic [4:0]       bit_cnt, bit_nxt;
  logic [31:0]      sh, sh_nxt;
  logic             last_q, last_nxt;
  logic             fifo_pop;
  logic             fifo_vld;
  logic [8:0]       fifo_dat;
  logic             sym_nxt;
  logic             done_nxt;
  logic             urun_nxt;

  bpsk_byte_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (in_valid),
    .wr_rdy (in_ready),
    .wr_dat ({in_last, in_byte}),
    .rd_rdy (fifo_pop),
    .rd_vld (fifo_vld),
    .rd_dat (fifo_dat)
  );

  assign boundary  = (cnt == CNT_MAX);
  // The shift register is cleared whenever the framer is idle, so its MSB is the line itself.
  assign data      = sh[31];
  assign tx_active = (state != S_IDLE);

  // Free-running carrier phase counter, independent of framer state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= boundary ? '0 : cnt + 1'b1;
  end

  // Framer state register and registered status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      sh         <= '0;
      last_q     <= 1'b0;
      sym_strobe <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_nxt;
      sh         <= sh_nxt;
      last_q     <= last_nxt;
      sym_strobe <= sym_nxt;
      frame_done <= done_nxt;
      underrun   <= urun_nxt;
    end
  end

  // Next-state logic; nothing moves except on a carrier boundary.
  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    sh_nxt    = sh;
    last_nxt  = last_q;
    fifo_pop  = 1'b0;
    done_nxt  = 1'b0;
    urun_nxt  = 1'b0;
    if (boundary) begin
      case (state)
        S_IDLE: begin
          sh_nxt = '0;
          if (fifo_vld) begin
            state_nxt = S_PRE;
            bit_nxt   = PRE_LAST_IDX;
            sh_nxt    = PRE_ALIGNED;
          end
        end
        S_PRE: begin
          if (bit_cnt == 5'd0) begin
            // The byte that opened the frame is still queued, so a pop is always valid here.
            state_nxt = S_DATA;
            fifo_pop  = 1'b1;
            bit_nxt   = 5'd7;
            sh_nxt    = {fifo_dat[7:0], 24'h0};
            last_nxt  = fifo_dat[8];
          end else begin
            bit_nxt = bit_cnt - 5'd1;
            sh_nxt  = {sh[30:0], 1'b0};
          end
        end
        S_DATA: begin
          if (bit_cnt == 5'd0) begin
            if (last_q) begin
              state_nxt = S_IDLE;
              sh_nxt    = '0;
              done_nxt  = 1'b1;
            end else if (fifo_vld) begin
              fifo_pop = 1'b1;
              bit_nxt  = 5'd7;
              sh_nxt   = {fifo_dat[7:0], 24'h0};
              last_nxt = fifo_dat[8];
            end else begin
              state_nxt = S_IDLE;
              sh_nxt    = '0;
              urun_nxt  = 1'b1;
            end
          end else begin
            bit_nxt = bit_cnt - 5'd1;
            sh_nxt  = {sh[30:0], 1'b0};
          end
        end
        default: begin
          state_nxt = S_IDLE;
          sh_nxt    = '0;
        end
      endcase
    end
    sym_nxt = boundary && (state_nxt != S_IDLE);
  end
endmodule
